// File: rtl/actor_mover_pkg.sv
// actor_mover_pkg: direction codes, FSM state type and a one-hot helper shared by actor_mover and turn_buffer
package actor_mover_pkg;

    localparam logic [3:0] DIR_L    = 4'b1000;
    localparam logic [3:0] DIR_U    = 4'b0100;
    localparam logic [3:0] DIR_R    = 4'b0010;
    localparam logic [3:0] DIR_D    = 4'b0001;
    localparam logic [3:0] DIR_NONE = 4'b0000;

    typedef enum logic [1:0] {S_IDLE, S_MOVING, S_BLOCKED, S_FROZEN} state_t;

    function automatic logic is_onehot(input logic [3:0] d);
        return d != 4'b0 && (d & (d - 4'd1)) == 4'b0;
    endfunction

endpackage

// File: rtl/turn_buffer.sv
// turn_buffer: holds a blocked turn request for a limited number of move ticks and decides when a direction is adopted
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_freeze     clears the buffer and suppresses all adoption
//   i_move_tick  movement strobe, ages the pending request
//   i_btn        one-hot request {L,U,R,D}; anything else is ignored
//   i_pass       passability at the current position
//   o_load       a new direction is adopted at the next edge
//   o_load_dir   the direction being adopted
//   o_pending    buffered turn request, one-hot or 0000
module turn_buffer
    import actor_mover_pkg::*;
#(
    parameter int HOLD_TICKS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_freeze,
    input  logic       i_move_tick,
    input  logic [3:0] i_btn,
    input  logic [3:0] i_pass,
    output logic       o_load,
    output logic [3:0] o_load_dir,
    output logic [3:0] o_pending
);

    logic [7:0] r_cnt;
    logic [3:0] r_pending;
    logic       w_btn_ok;
    logic       w_btn_pass;
    logic       w_pend_ok;

    always_comb begin
        w_btn_ok   = !i_freeze && is_onehot(i_btn);
        w_btn_pass = (i_btn & i_pass) != 4'b0;
        // a fresh button always wins over the buffered request
        w_pend_ok  = !i_freeze && !w_btn_ok && r_pending != DIR_NONE && (r_pending & i_pass) != 4'b0;
        o_load     = (w_btn_ok && w_btn_pass) || w_pend_ok;
        o_load_dir = w_btn_ok ? i_btn : r_pending;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_freeze) begin
            r_pending <= DIR_NONE;
            r_cnt     <= 8'd0;
        end else if (w_btn_ok) begin
            r_pending <= w_btn_pass ? DIR_NONE : i_btn;
            r_cnt     <= w_btn_pass ? 8'd0 : 8'(HOLD_TICKS);
        end else if (w_pend_ok) begin
            r_pending <= DIR_NONE;
            r_cnt     <= 8'd0;
        end else if (r_pending != DIR_NONE && i_move_tick) begin
            r_cnt     <= r_cnt - 8'd1;
            // the tick that takes the counter to zero drops the request
            if (r_cnt == 8'd1) r_pending <= DIR_NONE;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/actor_mover.sv
// actor_mover: grid actor position and direction FSM with buffered turns and horizontal tunnel wrap
//   i_clk_50mhz          clock
//   i_rst                synchronous active-high reset
//   i_move_tick          single-cycle movement strobe
//   i_gameover           freezes the block while high
//   i_btn                one-hot request {L,U,R,D}
//   i_pass               passability at current position {L,U,R,D}
//   o_p_x, o_p_y         actor position
//   o_going_direction    current direction, one-hot or 0000
//   o_pending_direction  buffered turn, one-hot or 0000
//   o_moving             high only in state MOVING
module actor_mover
    import actor_mover_pkg::*;
#(
    parameter int W          = 9,
    parameter int START_X    = 200,
    parameter int START_Y    = 230,
    parameter int VEL        = 1,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 447,
    parameter int HOLD_TICKS = 16
) (
    input  logic         i_clk_50mhz,
    input  logic         i_rst,
    input  logic         i_move_tick,
    input  logic         i_gameover,
    input  logic [3:0]   i_btn,
    input  logic [3:0]   i_pass,
    output logic [W-1:0] o_p_x,
    output logic [W-1:0] o_p_y,
    output logic [3:0]   o_going_direction,
    output logic [3:0]   o_pending_direction,
    output logic         o_moving
);

    localparam logic [W-1:0] VEL_W  = W'(VEL);
    localparam logic [W-1:0] XMIN_W = W'(X_MIN);
    localparam logic [W-1:0] XMAX_W = W'(X_MAX);
    // one extra bit so the limits never wrap for small X_MIN or large X_MAX
    localparam logic [W:0]   L_LIM  = (W+1)'(X_MIN + VEL);
    localparam logic [W:0]   R_LIM  = (W+1)'(X_MAX - VEL);

    state_t       r_state;
    state_t       w_state_nx;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] w_x_nx;
    logic [W-1:0] w_y_nx;
    logic [3:0]   r_going;
    logic [3:0]   w_load_dir;
    logic [3:0]   w_pending;
    logic         r_moving;
    logic         w_freeze;
    logic         w_load;
    logic         w_go_pass;
    logic         w_step;

    turn_buffer #(.HOLD_TICKS(HOLD_TICKS)) u_turn_buffer (
        .i_clk       (i_clk_50mhz),
        .i_rst       (i_rst),
        .i_freeze    (w_freeze),
        .i_move_tick (i_move_tick),
        .i_btn       (i_btn),
        .i_pass      (i_pass),
        .o_load      (w_load),
        .o_load_dir  (w_load_dir),
        .o_pending   (w_pending)
    );

    always_comb begin
        // FROZEN still ignores inputs during the cycle after gameover falls
        w_freeze   = i_gameover || r_state == S_FROZEN;
        w_go_pass  = (r_going & i_pass) != 4'b0;
        // movement uses the direction held before this edge, not one being adopted now
        w_step     = !w_freeze && i_move_tick && w_go_pass;
        w_x_nx     = !w_step ? r_x
                   : r_going == DIR_L ? ({1'b0, r_x} < L_LIM ? XMAX_W : r_x - VEL_W)
                   : r_going == DIR_R ? ({1'b0, r_x} > R_LIM ? XMIN_W : r_x + VEL_W)
                   : r_x;
        w_y_nx     = !w_step ? r_y
                   : r_going == DIR_U ? r_y - VEL_W
                   : r_going == DIR_D ? r_y + VEL_W
                   : r_y;
        w_state_nx = i_gameover ? S_FROZEN
                   : r_state == S_FROZEN ? (r_going == DIR_NONE ? S_IDLE : S_BLOCKED)
                   : r_state == S_IDLE ? (w_load ? S_MOVING : S_IDLE)
                   : i_move_tick ? (w_go_pass ? S_MOVING : S_BLOCKED)
                   : r_state;
    end

    always_ff @(posedge i_clk_50mhz) begin
        if (i_rst) begin
            r_x      <= W'(START_X);
            r_y      <= W'(START_Y);
            r_going  <= DIR_NONE;
            r_state  <= S_IDLE;
            r_moving <= 1'b0;
        end else begin
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_state  <= w_state_nx;
            r_moving <= w_state_nx == S_MOVING;
            if (w_load) r_going <= w_load_dir;
        end
    end

    assign o_p_x               = r_x;
    assign o_p_y               = r_y;
    assign o_going_direction   = r_going;
    assign o_pending_direction = w_pending;
    assign o_moving            = r_moving;

endmodule

// File: tb/tb_actor_mover.sv
// tb_actor_mover: directed vector table plus hand sequences for hold expiry, wrap, freeze and reset priority
module tb_actor_mover;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       gov = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] pass = 4'b0;
    logic [8:0] p_x;
    logic [8:0] p_y;
    logic [3:0] going;
    logic [3:0] pend;
    logic       moving;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       tick;
        logic       gov;
        logic [3:0] btn;
        logic [3:0] pass;
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] g;
        logic [3:0] p;
        logic       m;
    } vec_t;

    vec_t tbl[18];

    actor_mover dut (
        .i_clk_50mhz         (clk),
        .i_rst               (rst),
        .i_move_tick         (tick),
        .i_gameover          (gov),
        .i_btn               (btn),
        .i_pass              (pass),
        .o_p_x               (p_x),
        .o_p_y               (p_y),
        .o_going_direction   (going),
        .o_pending_direction (pend),
        .o_moving            (moving)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic t, input logic g, input logic [3:0] b, input logic [3:0] ps);
        rst = r;
        tick = t;
        gov = g;
        btn = b;
        pass = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input string f, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", nm, f, got, want);
        end
    endtask

    task automatic chk(input string nm, input int ex, input int ey, input int eg, input int ep, input int em);
        cmp(nm, "p_x", int'(p_x), ex);
        cmp(nm, "p_y", int'(p_y), ey);
        cmp(nm, "going", int'(going), eg);
        cmp(nm, "pending", int'(pend), ep);
        cmp(nm, "moving", int'(moving), em);
    endtask

    initial begin
        tbl[0]  = '{"reset",       1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 9'd200, 9'd230, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{"load_r",      1'b0, 1'b0, 1'b0, 4'b0010, 4'b1111, 9'd200, 9'd230, 4'b0010, 4'b0000, 1'b1};
        tbl[2]  = '{"tick1",       1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 9'd201, 9'd230, 4'b0010, 4'b0000, 1'b1};
        tbl[3]  = '{"tick2",       1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 9'd202, 9'd230, 4'b0010, 4'b0000, 1'b1};
        tbl[4]  = '{"tick3",       1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 9'd203, 9'd230, 4'b0010, 4'b0000, 1'b1};
        tbl[5]  = '{"not_onehot",  1'b0, 1'b0, 1'b0, 4'b0011, 4'b1111, 9'd203, 9'd230, 4'b0010, 4'b0000, 1'b1};
        tbl[6]  = '{"pend_u",      1'b0, 1'b0, 1'b0, 4'b0100, 4'b0010, 9'd203, 9'd230, 4'b0010, 4'b0100, 1'b1};
        tbl[7]  = '{"pend_tick1",  1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 9'd204, 9'd230, 4'b0010, 4'b0100, 1'b1};
        tbl[8]  = '{"pend_tick2",  1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 9'd205, 9'd230, 4'b0010, 4'b0100, 1'b1};
        tbl[9]  = '{"adopt_u",     1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 9'd205, 9'd230, 4'b0100, 4'b0000, 1'b1};
        tbl[10] = '{"move_u",      1'b0, 1'b1, 1'b0, 4'b0000, 4'b0110, 9'd205, 9'd229, 4'b0100, 4'b0000, 1'b1};
        tbl[11] = '{"pend_l",      1'b0, 1'b0, 1'b0, 4'b1000, 4'b0100, 9'd205, 9'd229, 4'b0100, 4'b1000, 1'b1};
        tbl[12] = '{"override_d",  1'b0, 1'b0, 1'b0, 4'b0001, 4'b0100, 9'd205, 9'd229, 4'b0100, 4'b0001, 1'b1};
        tbl[13] = '{"blocked",     1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 9'd205, 9'd229, 4'b0100, 4'b0001, 1'b0};
        tbl[14] = '{"unblocked",   1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 9'd205, 9'd228, 4'b0100, 4'b0001, 1'b1};
        tbl[15] = '{"adopt_d",     1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 9'd205, 9'd228, 4'b0001, 4'b0000, 1'b1};
        tbl[16] = '{"move_d",      1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 9'd205, 9'd229, 4'b0001, 4'b0000, 1'b1};
        tbl[17] = '{"load_r2",     1'b0, 1'b0, 1'b0, 4'b0010, 4'b1111, 9'd205, 9'd229, 4'b0010, 4'b0000, 1'b1};

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].rst, tbl[i].tick, tbl[i].gov, tbl[i].btn, tbl[i].pass);
            chk(tbl[i].name, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].g), int'(tbl[i].p), int'(tbl[i].m));
        end

        cyc(0, 0, 0, 4'b0001, 4'b0010);
        chk("hold_load", 205, 229, 4'b0010, 4'b0001, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 1, 0, 4'b0000, 4'b0010);
            cmp("hold_tick", "pending", int'(pend), k < 16 ? 1 : 0);
            cmp("hold_tick", "p_x", int'(p_x), 205 + k);
            cyc(0, 0, 0, 4'b0000, 4'b0010);
        end

        cyc(0, 0, 0, 4'b1000, 4'b1111);
        chk("load_l", 221, 229, 4'b1000, 4'b0000, 1);
        for (int k = 0; k < 221; k++) cyc(0, 1, 0, 4'b0000, 4'b1000);
        chk("reach_0", 0, 229, 4'b1000, 4'b0000, 1);
        cyc(0, 1, 0, 4'b0000, 4'b1000);
        chk("wrap_l", 447, 229, 4'b1000, 4'b0000, 1);
        cyc(0, 0, 0, 4'b0010, 4'b0010);
        chk("load_r3", 447, 229, 4'b0010, 4'b0000, 1);
        cyc(0, 1, 0, 4'b0000, 4'b0010);
        chk("wrap_r", 0, 229, 4'b0010, 4'b0000, 1);

        cyc(0, 0, 0, 4'b0100, 4'b0010);
        chk("pre_freeze", 0, 229, 4'b0010, 4'b0100, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, k[0] ? 4'b1000 : 4'b0100, 4'b1111);
            chk("frozen", 0, 229, 4'b0010, 4'b0000, 0);
        end
        cyc(0, 1, 0, 4'b0100, 4'b1111);
        chk("unfreeze", 0, 229, 4'b0010, 4'b0000, 0);
        cyc(0, 1, 0, 4'b0000, 4'b1111);
        chk("resume", 1, 229, 4'b0010, 4'b0000, 1);

        cyc(0, 0, 0, 4'b0001, 4'b0010);
        chk("pre_rst", 1, 229, 4'b0010, 4'b0001, 1);
        cyc(1, 1, 0, 4'b0100, 4'b1111);
        chk("rst_prio", 200, 230, 4'b0000, 4'b0000, 0);
        cyc(0, 1, 0, 4'b0000, 4'b1111);
        chk("idle_tick", 200, 230, 4'b0000, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
